// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes and dump FSM states.
package data_mem_responder_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // 2'b11 is an alias for a full-word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size != SIZE_HALF) && (size != SIZE_BYTE);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_load_align.sv
// Lane selection, load extension, store merge and misalignment check for one
// addressed memory word; purely combinational.
module mem_load_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  input  logic        access,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        misaligned
);

  logic [4:0]  shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shift    = {lane, 3'b000};
  assign byte_sel = 8'(word >> shift);
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    load_data   = word;
    merged_word = store_data;
    misaligned  = access && (((size == SIZE_HALF) && lane[0]) ||
                             (is_word(size) && (lane != 2'b00)));
    case (size)
      SIZE_HALF: begin
        load_data   = {{16{~zero_ext & half_sel[15]}}, half_sel};
        merged_word = lane[1] ? {store_data[15:0], word[15:0]}
                              : {word[31:16], store_data[15:0]};
      end
      SIZE_BYTE: begin
        load_data   = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
        merged_word = (word & ~(32'h0000_00FF << shift)) |
                      ({24'b0, store_data[7:0]} << shift);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory for the MEM stage with byte/half/word access and a debug dump
// engine streaming every word over a valid/ready handshake.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  input  logic [1:0]        ByteSig,
  input  logic              Unsigned,
  output logic [31:0]       ReadData,
  output logic              Misaligned,
  input  logic              DumpStart,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic [31:0]       DumpData,
  output logic              DumpDone
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       load_data;
  logic [31:0]       merged_word;
  logic [1:0]        state;
  logic [ADDR_W-1:0] dump_idx;
  logic              unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx       = Address[ADDR_W+1:2];
  assign unused_addr_hi = ^Address[31:ADDR_W+2];

  mem_load_align u_align (
    .word        (mem[word_idx]),
    .lane        (Address[1:0]),
    .size        (ByteSig),
    .zero_ext    (Unsigned),
    .access      (MemRead | MemWrite),
    .store_data  (WriteData),
    .load_data   (load_data),
    .merged_word (merged_word),
    .misaligned  (Misaligned)
  );

  assign ReadData = (MemRead && !Misaligned) ? load_data : 32'h0;

  // NOTE: the array is reset explicitly because reset must clear every word,
  // which forces it into flops rather than a RAM macro.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (MemWrite && !Misaligned) begin
      mem[word_idx] <= merged_word;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the same pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      dump_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: if (DumpStart) begin
          state    <= ST_SEND;
          dump_idx <= '0;
        end
        ST_SEND: if (DumpReady) begin
          if (dump_idx == LAST_IDX) state <= ST_DONE;
          else dump_idx <= dump_idx + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Dump data is read live so a store to the held word shows up immediately.
  assign DumpValid = (state == ST_SEND);
  assign DumpDone  = (state == ST_DONE);
  assign DumpAddr  = dump_idx;
  assign DumpData  = mem[dump_idx];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: loads/stores, misalignment,
// address wrap, dump with backpressure and reset during a dump.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset, MemWrite, MemRead, Unsigned, DumpStart, DumpReady;
  logic [31:0] Address, WriteData;
  logic [1:0]  ByteSig;
  logic [31:0] ReadData, DumpData;
  logic        Misaligned, DumpValid, DumpDone;
  logic [4:0]  DumpAddr;

  int total = 0;
  int bad   = 0;
  int beat, done_cnt, last_hs_n;

  always #5 Clock = ~Clock;

  data_mem_responder dut (
    .Clock(Clock), .Reset(Reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ByteSig(ByteSig), .Unsigned(Unsigned),
    .ReadData(ReadData), .Misaligned(Misaligned), .DumpStart(DumpStart),
    .DumpValid(DumpValid), .DumpReady(DumpReady), .DumpAddr(DumpAddr),
    .DumpData(DumpData), .DumpDone(DumpDone)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    @(negedge Clock);
    MemWrite = 1'b1; MemRead = 1'b0; Address = addr; WriteData = data; ByteSig = size;
    @(posedge Clock);
    #1 MemWrite = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] exp_data, input logic exp_mis);
    @(negedge Clock);
    MemRead = 1'b1; MemWrite = 1'b0; Address = addr; ByteSig = size; Unsigned = uns;
    #1;
    check(tag, ReadData, exp_data);
    check({tag, "_mis"}, {31'b0, Misaligned}, {31'b0, exp_mis});
    MemRead = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; Unsigned = 1'b0;
    DumpStart = 1'b0; DumpReady = 1'b0; Address = '0; WriteData = '0; ByteSig = SIZE_WORD;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_valid", {31'b0, DumpValid}, 32'h0);
    check("rst_done", {31'b0, DumpDone}, 32'h0);
    check("rst_addr", 32'(DumpAddr), 32'h0);
    MemRead = 1'b1; Address = 32'h08; #1;
    check("rst_read", ReadData, 32'h0);
    MemRead = 1'b0;
    @(negedge Clock) Reset = 1'b0;

    // Word round trip and load extension
    store(32'h08, 32'hDEADBEEF, SIZE_WORD);
    load_check("lw_08", 32'h08, SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0);
    load_check("lb_0b", 32'h0B, SIZE_BYTE, 1'b0, 32'hFFFFFFDE, 1'b0);
    load_check("lbu_0b", 32'h0B, SIZE_BYTE, 1'b1, 32'h000000DE, 1'b0);
    load_check("lh_0a", 32'h0A, SIZE_HALF, 1'b0, 32'hFFFFDEAD, 1'b0);
    load_check("lhu_08", 32'h08, SIZE_HALF, 1'b1, 32'h0000BEEF, 1'b0);
    load_check("lb_08_pos", 32'h08, SIZE_BYTE, 1'b0, 32'hFFFFFFEF, 1'b0);
    load_check("lw_alias11", 32'h08, 2'b11, 1'b0, 32'hDEADBEEF, 1'b0);

    // Partial stores
    store(32'h09, 32'hFFFFFF55, SIZE_BYTE);
    load_check("sb_09", 32'h08, SIZE_WORD, 1'b0, 32'hDEAD55EF, 1'b0);
    store(32'h0A, 32'hABCD1234, SIZE_HALF);
    load_check("sh_0a", 32'h08, SIZE_WORD, 1'b0, 32'h123455EF, 1'b0);

    // Misaligned store leaves memory alone
    @(negedge Clock);
    MemWrite = 1'b1; Address = 32'h0A; WriteData = 32'hCAFEF00D; ByteSig = SIZE_WORD;
    #1 check("sw_0a_mis", {31'b0, Misaligned}, 32'h1);
    @(posedge Clock);
    #1 MemWrite = 1'b0;
    load_check("sw_0a_nochg", 32'h08, SIZE_WORD, 1'b0, 32'h123455EF, 1'b0);
    load_check("lh_03", 32'h03, SIZE_HALF, 1'b0, 32'h0, 1'b1);

    // No access: misaligned address flags nothing and read data is zero
    @(negedge Clock);
    MemRead = 1'b0; MemWrite = 1'b0; Address = 32'h09; ByteSig = SIZE_WORD;
    #1;
    check("idle_mis", {31'b0, Misaligned}, 32'h0);
    check("idle_read", ReadData, 32'h0);

    // Address wrap
    store(32'h80, 32'h00000077, SIZE_WORD);
    load_check("wrap_0", 32'h00, SIZE_WORD, 1'b0, 32'h00000077, 1'b0);

    // Simultaneous read/write: pre-write data visible, write commits at the edge
    store(32'h10, 32'h11111111, SIZE_WORD);
    @(negedge Clock);
    MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h10; WriteData = 32'hA5A5A5A5; ByteSig = SIZE_WORD;
    #1 check("rw_pre", ReadData, 32'h11111111);
    @(posedge Clock);
    #1 begin MemRead = 1'b0; MemWrite = 1'b0; end
    load_check("rw_post", 32'h10, SIZE_WORD, 1'b0, 32'hA5A5A5A5, 1'b0);

    // Dump with backpressure
    for (int k = 0; k < 32; k++) store(32'(k * 4), 32'(k + 1), SIZE_WORD);
    @(negedge Clock) DumpStart = 1'b1;
    @(negedge Clock) DumpStart = 1'b0;
    beat = 0; done_cnt = 0; last_hs_n = -10;
    for (int n = 0; n < 200 && done_cnt == 0; n++) begin
      DumpReady = n[0];
      #1;
      if (DumpDone) begin
        done_cnt++;
        check("dump_done_timing", 32'(n), 32'(last_hs_n + 1));
      end else if (DumpValid) begin
        check("dump_addr", 32'(DumpAddr), 32'(beat));
        check("dump_data", DumpData, 32'(beat + 1));
        if (DumpReady) begin
          beat++;
          if (beat == 32) last_hs_n = n;
        end
      end
      @(negedge Clock);
    end
    DumpReady = 1'b0;
    check("dump_beats", 32'(beat), 32'd32);
    check("dump_done_cnt", 32'(done_cnt), 32'd1);
    for (int n = 0; n < 3; n++) begin
      #1;
      check("post_dump_done", {31'b0, DumpDone}, 32'h0);
      check("post_dump_valid", {31'b0, DumpValid}, 32'h0);
      @(negedge Clock);
    end

    // Reset during a dump
    DumpStart = 1'b1; DumpReady = 1'b1;
    @(negedge Clock) DumpStart = 1'b0;
    beat = 0;
    for (int n = 0; n < 100 && beat < 10; n++) begin
      #1;
      if (DumpValid) beat++;
      @(negedge Clock);
    end
    #1 check("mid_dump_addr", 32'(DumpAddr), 32'd10);
    Reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'b0, DumpValid}, 32'h0);
    check("mid_rst_done", {31'b0, DumpDone}, 32'h0);
    check("mid_rst_addr", 32'(DumpAddr), 32'h0);
    @(negedge Clock) Reset = 1'b0;
    DumpReady = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1 check("after_rst_done", {31'b0, DumpDone}, 32'h0);
      @(negedge Clock);
    end
    for (int k = 0; k < 32; k++)
      load_check("cleared_word", 32'(k * 4), SIZE_WORD, 1'b0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the MIPS pipeline. It services load/store requests issued by the MEM stage: word, halfword and byte accesses, with sign or zero extension on loads.
- It also contains a debug dump engine. The engine streams the full memory contents to the debug/UART unit over a valid/ready handshake.
- It sits below the MEM stage and beside the debug unit.

Parameters:
- DEPTH, 32, number of 32-bit words in memory.
- ADDR_W, 5, word-index width; must equal log2(DEPTH).

Ports:
- Clock  input  1  system clock, rising-edge active.
- Reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  store request this cycle.
- MemRead  input  1  load request this cycle.
- Address  input  32  byte address (ALU result).
- WriteData  input  32  store data (RT register); the low bytes are used for half/byte stores.
- ByteSig  input  2  access size: 00 = word, 01 = halfword, 10 = byte, 11 = word.
- Unsigned  input  1  1 = zero-extend loads (LBU/LHU); 0 = sign-extend.
- ReadData  output  32  extended load data.
- Misaligned  output  1  current access is misaligned.
- DumpStart  input  1  one-cycle pulse that starts a full memory dump.
- DumpValid  output  1  DumpAddr/DumpData hold a valid beat.
- DumpReady  input  1  consumer accepts the beat.
- DumpAddr  output  ADDR_W  word index of the current beat.
- DumpData  output  32  word contents of the current beat.
- DumpDone  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous):
  - All DEPTH words clear to 0.
  - The dump FSM goes to IDLE.
  - DumpValid=0, DumpDone=0, DumpAddr=0.
  - ReadData and Misaligned reflect the cleared memory (combinational).
- Addressing:
  - Word index = Address[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = Address[1:0]; lane 0 is bits 7:0 (little-endian).
- Misaligned:
  - Asserted when (MemRead|MemWrite) and either (halfword with Address[0]=1) or (word with Address[1:0]!=0).
  - A misaligned store does not modify memory.
  - A misaligned load drives ReadData=0.
- Loads:
  - Combinational, zero latency; ReadData is valid in the same cycle as MemRead.
  - Word: the full word.
  - Halfword: lane pair Address[1]; bit 15 extended unless Unsigned.
  - Byte: the selected lane; bit 7 extended unless Unsigned.
  - MemRead=0 drives ReadData=0.
- Stores:
  - Take effect on the rising edge while MemWrite=1.
  - Byte stores write only the selected lane from WriteData[7:0].
  - Halfword stores write the selected half from WriteData[15:0].
  - All other lanes are preserved.
- MemRead and MemWrite together in one cycle: ReadData shows the pre-write contents; the write commits at the edge.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE: DumpStart=1 → SEND with index=0 and DumpValid=1.
  - SEND: DumpData = mem[index], combinational, so it always shows current contents.
  - SEND: on DumpValid&DumpReady, if index==DEPTH-1 go to DONE; otherwise index+1.
  - SEND: while DumpReady=0, DumpAddr is held; DumpData may change only if a store hits that word.
  - DONE: DumpDone=1 for one cycle, DumpValid=0, then IDLE.
  - DumpStart is ignored in SEND and DONE.
  - Pipeline stores during a dump still execute; words already sent are not re-sent.
- Reset asserted mid-dump aborts immediately to IDLE with no DumpDone.

Decomposition:
- Shared package holds the ByteSig encodings (SIZE_WORD=2'b00, SIZE_HALF=2'b01, SIZE_BYTE=2'b10) and the dump state encodings (IDLE, SEND, DONE).
- One sub-module: mem_load_align. It is purely combinational: lane select plus sign/zero extension and the misalignment check. It is shared by the load path and the store-merge logic.

Test Plan:
- Word round trip: SW 0xDEADBEEF to 0x08, then LW 0x08 → ReadData=0xDEADBEEF, Misaligned=0.
- Byte/half extension:
  - After the word round trip, LB 0x0B → 0xFFFFFFDE; LBU 0x0B → 0x000000DE.
  - LH 0x0A → 0xFFFFDEAD; LHU 0x08 → 0x0000BEEF.
- Partial stores:
  - SB 0x55 to 0x09 over 0xDEADBEEF → LW 0x08 = 0xDEAD55EF.
  - SH 0x1234 to 0x0A → 0x123455EF.
- Misalignment and wrap:
  - SW to 0x0A → Misaligned=1 and memory unchanged.
  - LH 0x03 → ReadData=0, Misaligned=1.
  - SW 0x77 to 0x80 → word 0 = 0x77 (wrap with DEPTH=32).
- Dump with backpressure:
  - Preload word k = k+1, pulse DumpStart, toggle DumpReady every other cycle.
  - Expect exactly 32 beats with DumpAddr 0..31 and DumpData 1..32 in order.
  - Expect a single DumpDone pulse one cycle after the last handshake.
- Reset mid-dump: assert Reset after beat 10 → DumpValid=0 immediately, no DumpDone, and all words read 0 afterwards.
